modexp_ctrl: RTL and testbench
==============================

MODEXP_CTRL -- requirements
Module: modexp_ctrl

Interface
REQ-001 Parameter BITS, default 64, operand width of message, exponent, modulus and result.
REQ-002 CLK  in  1  clock; all state changes on posedge CLK.
REQ-003 RESET  in  1  synchronous, active-high reset.
REQ-004 START  in  1  one-cycle request to begin an exponentiation with current m, e, n, r2.
REQ-005 m, e, n  in  BITS each  message, exponent, odd modulus (from loaded operand registers).
REQ-006 r2  in  BITS  R^2 mod n, R = 2^BITS, precomputed by software.
REQ-007 mm_start  out  1  one-cycle pulse issuing a Montgomery multiply.
REQ-008 mm_a, mm_b  out  BITS each  multiplier operands, registered.
REQ-009 mm_done  in  1  one-cycle pulse; mm_p valid in the same cycle.
REQ-010 mm_p  in  BITS  multiplier product a*b*R^-1 mod n.
REQ-011 r  out  BITS  final result m^e mod n.
REQ-012 done  out  1  level; result valid.
REQ-013 busy  out  1  high from the cycle after accepted START until done rises.

Function
REQ-014 States: IDLE, TOM_M, TOM_X, SQR, MUL, FROMM, FIN; each op state has an issue phase and a wait phase.
REQ-015 IDLE: START captures m, e, n, r2 into internal registers, sets bit index = BITS-1, clears done, enters TOM_M.
REQ-016 TOM_M: mbar = MM(m, r2); TOM_X: xbar = MM(1, r2).
REQ-017 SQR: xbar = MM(xbar, xbar); then MUL if e[idx]=1, else proceed to the next bit.
REQ-018 MUL: xbar = MM(mbar, xbar); then proceed to the next bit.
REQ-019 Next bit: if idx = 0 go to FROMM; else decrement idx and go to SQR.
REQ-020 FROMM: r = MM(xbar, 1); on mm_done load r, assert done, enter FIN.
REQ-021 FIN: done held high and r held stable until the next accepted START; FIN accepts START the same as IDLE.
REQ-022 Issue phase: mm_a/mm_b valid and mm_start high for exactly one cycle; wait phase: mm_a/mm_b held stable, mm_start low.
REQ-023 The next mm_start occurs no earlier than the cycle after the mm_done that completes the previous op.
REQ-024 mm_done is ignored outside a wait phase.
REQ-025 Total multiplies = 3 + BITS + popcount(e).
REQ-026 All BITS exponent bits are processed with no leading-zero skip, so timing depends only on popcount(e).
REQ-027 START is ignored while busy; inputs m, e, n, r2 may change after acceptance without effect.
REQ-028 e = 0 yields r = 1 mod n.
REQ-029 done rises in the cycle after the final mm_done; busy falls in the same cycle.

Reset
REQ-030 RESET in any state forces IDLE; mm_start=0, done=0, busy=0, r=0, mm_a=mm_b=0, idx=BITS-1.
REQ-031 RESET mid-operation abandons the operation; a later mm_done from the multiplier is ignored.
REQ-032 RESET has priority over START in the same cycle.

Structure
REQ-033 Shared package modexp_pkg holds BITS and the state encoding; the multiplier and operand memory interface import it.
REQ-034 No sub-module; the Montgomery multiplier is a sibling instance outside this block.

Verification
REQ-035 BITS=64, behavioural MM model with latency 5; m=4, e=13, n=497, r2=2^128 mod 497, START -> r=445, done=1, exactly 70 mm_start pulses.
REQ-036 e=0, m=7, n=11 -> r=1 after 67 multiplies; done holds until the next START.
REQ-037 e=2^64-1, m=2, n=2^61-1 -> r equals the reference model result; 131 multiplies; mm_start never in consecutive cycles.
REQ-038 START pulsed again at multiply 10 while busy -> ignored; result and pulse count unchanged from the single-START case.
REQ-039 RESET asserted during SQR wait, with the model's mm_done arriving 2 cycles later -> IDLE, outputs zero, no further mm_start; subsequent START of the first case gives r=445.
REQ-040 Randomised MM latency of 1-20 cycles, with spurious mm_done pulses during the issue phase and while in IDLE -> results unaffected and mm_a/mm_b stable during every wait phase.

Source files
------------

// File: rtl/modexp_pkg.sv
// Shared definitions for the modular exponentiation controller and the
// blocks around it (Montgomery multiplier, operand registers).
package modexp_pkg;

   // Operand width of message, exponent, modulus and result.
   localparam int MODEXP_BITS = 64;

   // Controller states. Each multiply state (TOM_M .. FROMM) is split into
   // an issue phase and a wait phase, tracked by modexp_phase_e.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TOM_M = 3'd1,
      ST_TOM_X = 3'd2,
      ST_SQR   = 3'd3,
      ST_MUL   = 3'd4,
      ST_FROMM = 3'd5,
      ST_FIN   = 3'd6
   } modexp_state_e;

   typedef enum logic {
      PH_ISSUE = 1'b0,
      PH_WAIT  = 1'b1
   } modexp_phase_e;

endpackage

// File: rtl/modexp_ctrl.sv
// Left-to-right square-and-multiply controller driving an external
// Montgomery multiplier (MM(a,b) = a*b*R^-1 mod n, R = 2^BITS).
//
// Multiplier handshake: mm_start is a one-cycle pulse, registered, with
// mm_a/mm_b valid in that same cycle (issue phase). mm_a/mm_b then stay
// frozen until mm_done, a one-cycle pulse with mm_p valid in the same cycle,
// is seen during the wait phase. The next mm_start is launched from the
// edge that samples mm_done, so it appears one cycle later at the earliest.
// mm_done seen in any other phase or state is ignored.
module modexp_ctrl
   import modexp_pkg::*;
#(
   parameter int BITS = MODEXP_BITS
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            START,
   input  logic [BITS-1:0] m,
   input  logic [BITS-1:0] e,
   input  logic [BITS-1:0] n,
   input  logic [BITS-1:0] r2,
   output logic            mm_start,
   output logic [BITS-1:0] mm_a,
   output logic [BITS-1:0] mm_b,
   output logic [BITS-1:0] mm_n,
   input  logic            mm_done,
   input  logic [BITS-1:0] mm_p,
   output logic [BITS-1:0] r,
   output logic            done,
   output logic            busy,
   output modexp_state_e   state_o,
   output modexp_phase_e   phase_o
);

   localparam int              IW      = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [IW-1:0]   IDX_TOP = IW'(BITS - 1);
   localparam logic [BITS-1:0] ONE     = BITS'(1);

   modexp_state_e   state_q, state_d;
   modexp_phase_e   phase_q, phase_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [BITS-1:0] e_q, e_d;
   logic [BITS-1:0] n_q, n_d;
   logic [BITS-1:0] r2_q, r2_d;
   logic [BITS-1:0] mbar_q, mbar_d;
   logic [BITS-1:0] mm_a_q, mm_a_d;
   logic [BITS-1:0] mm_b_q, mm_b_d;
   logic            mm_start_q, mm_start_d;
   logic [BITS-1:0] r_q, r_d;
   logic            done_q, done_d;

   // State and operand registers; synchronous reset wins over everything.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= ST_IDLE;
         phase_q    <= PH_ISSUE;
         idx_q      <= IDX_TOP;
         e_q        <= '0;
         n_q        <= '0;
         r2_q       <= '0;
         mbar_q     <= '0;
         mm_a_q     <= '0;
         mm_b_q     <= '0;
         mm_start_q <= 1'b0;
         r_q        <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         e_q        <= e_d;
         n_q        <= n_d;
         r2_q       <= r2_d;
         mbar_q     <= mbar_d;
         mm_a_q     <= mm_a_d;
         mm_b_q     <= mm_b_d;
         mm_start_q <= mm_start_d;
         r_q        <= r_d;
         done_q     <= done_d;
      end
   end

   // Next-state logic: each completed multiply selects the next op and loads
   // its operands. The running value xbar is never stored separately: it is
   // always the mm_p just returned, fed straight into the next operands.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      idx_d      = idx_q;
      e_d        = e_q;
      n_d        = n_q;
      r2_d       = r2_q;
      mbar_d     = mbar_q;
      mm_a_d     = mm_a_q;
      mm_b_d     = mm_b_q;
      mm_start_d = 1'b0;
      r_d        = r_q;
      done_d     = done_q;

      case (state_q)
         ST_IDLE, ST_FIN: begin
            if (START) begin
               e_d        = e;
               n_d        = n;
               r2_d       = r2;
               idx_d      = IDX_TOP;
               done_d     = 1'b0;
               state_d    = ST_TOM_M;
               phase_d    = PH_ISSUE;
               mm_a_d     = m;
               mm_b_d     = r2;
               mm_start_d = 1'b1;
            end
         end
         default: begin
            if (phase_q == PH_ISSUE) begin
               phase_d = PH_WAIT;
            end else if (mm_done) begin
               phase_d    = PH_ISSUE;
               mm_start_d = 1'b1;
               if (state_q == ST_TOM_M) begin
                  mbar_d  = mm_p;
                  state_d = ST_TOM_X;
                  mm_a_d  = ONE;
                  mm_b_d  = r2_q;
               end else if (state_q == ST_FROMM) begin
                  r_d        = mm_p;
                  done_d     = 1'b1;
                  state_d    = ST_FIN;
                  mm_start_d = 1'b0;
               end else if (state_q == ST_TOM_X) begin
                  state_d = ST_SQR;
                  mm_a_d  = mm_p;
                  mm_b_d  = mm_p;
               end else if (state_q == ST_SQR && e_q[idx_q]) begin
                  state_d = ST_MUL;
                  mm_a_d  = mbar_q;
                  mm_b_d  = mm_p;
               end else if (idx_q == '0) begin
                  state_d = ST_FROMM;
                  mm_a_d  = mm_p;
                  mm_b_d  = ONE;
               end else begin
                  idx_d   = idx_q - IW'(1);
                  state_d = ST_SQR;
                  mm_a_d  = mm_p;
                  mm_b_d  = mm_p;
               end
            end
         end
      endcase
   end

   assign mm_start = mm_start_q;
   assign mm_a     = mm_a_q;
   assign mm_b     = mm_b_q;
   assign mm_n     = n_q;
   assign r        = r_q;
   assign done     = done_q;
   assign busy     = (state_q != ST_IDLE) && (state_q != ST_FIN);
   assign state_o  = state_q;
   assign phase_o  = phase_q;

endmodule

// File: tb/tb_modexp_ctrl.sv
// Bench for modexp_ctrl: behavioural Montgomery multiplier with configurable
// latency and spurious done pulses, plus a plain modular-exponentiation
// reference model feeding an expected-result queue.
module tb_modexp_ctrl;
   import modexp_pkg::*;

   localparam int BITS = 64;

   logic            CLK = 1'b0;
   logic            RESET = 1'b1;
   logic            START = 1'b0;
   logic [BITS-1:0] m_in = '0;
   logic [BITS-1:0] e_in = '0;
   logic [BITS-1:0] n_in = '0;
   logic [BITS-1:0] r2_in = '0;
   logic            mm_start;
   logic [BITS-1:0] mm_a;
   logic [BITS-1:0] mm_b;
   logic [BITS-1:0] mm_n;
   logic            mm_done = 1'b0;
   logic [BITS-1:0] mm_p = '0;
   logic [BITS-1:0] r;
   logic            done;
   logic            busy;
   modexp_state_e   state_o;
   modexp_phase_e   phase_o;

   modexp_ctrl #(.BITS(BITS)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .START    (START),
      .m        (m_in),
      .e        (e_in),
      .n        (n_in),
      .r2       (r2_in),
      .mm_start (mm_start),
      .mm_a     (mm_a),
      .mm_b     (mm_b),
      .mm_n     (mm_n),
      .mm_done  (mm_done),
      .mm_p     (mm_p),
      .r        (r),
      .done     (done),
      .busy     (busy),
      .state_o  (state_o),
      .phase_o  (phase_o)
   );

   // Clock
   always #5 CLK = ~CLK;

   int              n_checks = 0;
   int              n_errors = 0;
   logic [BITS-1:0] exp_q[$];

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // a*b*2^-64 mod nn, by reducing the product and halving mod nn 64 times.
   function automatic logic [63:0] mont(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] nn);
      logic [127:0] x;
      if (nn == 64'd0) return 64'd0;
      x = (128'(a) * 128'(b)) % 128'(nn);
      for (int i = 0; i < 64; i++) x = x[0] ? ((x + 128'(nn)) >> 1) : (x >> 1);
      return x[63:0];
   endfunction

   // Reference m^e mod n, right-to-left binary method.
   function automatic logic [63:0] powmod(input logic [63:0] b, input logic [63:0] ex,
                                           input logic [63:0] nn);
      logic [127:0] res;
      logic [127:0] base;
      res  = 128'd1 % 128'(nn);
      base = 128'(b) % 128'(nn);
      for (int i = 0; i < 64; i++) begin
         if (ex[i]) res = (res * base) % 128'(nn);
         base = (base * base) % 128'(nn);
      end
      return res[63:0];
   endfunction

   function automatic logic [63:0] r2_of(input logic [63:0] nn);
      logic [127:0] t;
      t = (128'd1 << 64) % 128'(nn);
      t = (t * t) % 128'(nn);
      return t[63:0];
   endfunction

   // Multiplier model state
   int              fixed_lat = 5;
   bit              spur_en = 1'b0;
   bit              mm_pend = 1'b0;
   int              mm_rem = 0;
   int              mm_cnt = 0;
   logic            prev_start = 1'b0;
   logic [63:0]     lat_a = '0;
   logic [63:0]     lat_b = '0;
   logic [63:0]     mm_res = '0;
   logic [63:0]     n_cur = '0;

   // Behavioural Montgomery multiplier, driven on the falling edge.
   always @(negedge CLK) begin
      mm_done = 1'b0;
      mm_p    = '0;
      if (mm_start) begin
         check("mm_start_gap", 128'(prev_start), 128'(1'b0));
         check("mm_start_while_pending", 128'(mm_pend), 128'(1'b0));
         if (busy) check("mm_n_captured", 128'(mm_n), 128'(n_cur));
         lat_a   = mm_a;
         lat_b   = mm_b;
         mm_res  = mont(mm_a, mm_b, mm_n);
         mm_pend = 1'b1;
         mm_rem  = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, 20));
         mm_cnt++;
         if (spur_en && $urandom_range(0, 1) == 1) begin
            mm_done = 1'b1;
            mm_p    = {$urandom, $urandom};
         end
      end else if (mm_pend) begin
         if (busy) begin
            check("wait_a_stable", 128'(mm_a), 128'(lat_a));
            check("wait_b_stable", 128'(mm_b), 128'(lat_b));
         end
         if (mm_rem <= 1) begin
            mm_done = 1'b1;
            mm_p    = mm_res;
            mm_pend = 1'b0;
         end else begin
            mm_rem--;
         end
      end else if (spur_en && !busy && $urandom_range(0, 3) == 0) begin
         mm_done = 1'b1;
         mm_p    = {$urandom, $urandom};
      end
      prev_start = mm_start;
   end

   // Driver: one exponentiation, optional extra START while busy.
   task automatic run_case(input string name, input logic [63:0] mi, input logic [63:0] ei,
                           input logic [63:0] ni, input int lat, input bit spur,
                           input int restart_at);
      logic [63:0] expv;
      logic [63:0] got_r;
      int          exp_cnt;
      int          cyc;
      bit          resent;
      expv    = powmod(mi, ei, ni);
      exp_q.push_back(expv);
      exp_cnt = 3 + BITS + $countones(ei);
      @(negedge CLK);
      fixed_lat = lat;
      spur_en   = spur;
      n_cur     = ni;
      m_in      = mi;
      e_in      = ei;
      n_in      = ni;
      r2_in     = r2_of(ni);
      mm_cnt    = 0;
      START     = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      check({name, "_busy_after_start"}, 128'(busy), 128'(1'b1));
      check({name, "_done_cleared"}, 128'(done), 128'(1'b0));
      check({name, "_first_issue"}, 128'(mm_start), 128'(1'b1));
      check({name, "_first_a"}, 128'(mm_a), 128'(mi));
      check({name, "_first_b"}, 128'(mm_b), 128'(r2_of(ni)));
      m_in  = {$urandom, $urandom};
      e_in  = {$urandom, $urandom};
      n_in  = {$urandom, $urandom};
      r2_in = {$urandom, $urandom};
      cyc    = 0;
      resent = 1'b0;
      while (!done && cyc < 20000) begin
         @(negedge CLK);
         cyc++;
         START = 1'b0;
         if (restart_at > 0 && !resent && mm_cnt >= restart_at) begin
            START  = 1'b1;
            m_in   = {$urandom, $urandom};
            resent = 1'b1;
         end
      end
      START = 1'b0;
      check({name, "_done_within_budget"}, 128'(done), 128'(1'b1));
      check({name, "_busy_falls_with_done"}, 128'(busy), 128'(1'b0));
      got_r = r;
      check({name, "_result"}, 128'(got_r), 128'(exp_q.pop_front()));
      check({name, "_mm_count"}, 128'(mm_cnt), 128'(exp_cnt));
      repeat (4) @(negedge CLK);
      check({name, "_done_held"}, 128'(done), 128'(1'b1));
      check({name, "_r_held"}, 128'(r), 128'(expv));
      check({name, "_no_extra_mm"}, 128'(mm_cnt), 128'(exp_cnt));
   endtask

   // Abandon an operation with RESET while a square is in its wait phase.
   task automatic reset_mid_sqr();
      int cyc;
      int cnt_snap;
      @(negedge CLK);
      fixed_lat = 5;
      spur_en   = 1'b0;
      n_cur     = 64'd497;
      m_in      = 64'd4;
      e_in      = 64'd13;
      n_in      = 64'd497;
      r2_in     = r2_of(64'd497);
      mm_cnt    = 0;
      START     = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      cyc   = 0;
      while (!(state_o == ST_SQR && phase_o == PH_WAIT && mm_pend && mm_rem == 2 && mm_cnt >= 5)
             && cyc < 2000) begin
         @(negedge CLK);
         cyc++;
      end
      check("rst_reached_sqr_wait", 128'(cyc < 2000), 128'(1'b1));
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check("rst_state_idle", 128'(state_o), 128'(ST_IDLE));
      check("rst_busy", 128'(busy), 128'(1'b0));
      check("rst_done", 128'(done), 128'(1'b0));
      check("rst_r", 128'(r), 128'(0));
      check("rst_mm_a", 128'(mm_a), 128'(0));
      check("rst_mm_b", 128'(mm_b), 128'(0));
      check("rst_mm_start", 128'(mm_start), 128'(1'b0));
      cnt_snap = mm_cnt;
      repeat (12) @(negedge CLK);
      check("rst_no_more_mm_start", 128'(mm_cnt), 128'(cnt_snap));
      check("rst_stale_done_ignored", 128'(state_o), 128'(ST_IDLE));
      check("rst_done_stays_low", 128'(done), 128'(1'b0));
   endtask

   // Run-away guard
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
      $fatal(1, "watchdog");
   end

   // Main sequence
   initial begin
      logic [63:0] mi;
      logic [63:0] ei;
      logic [63:0] ni;
      RESET   = 1'b1;
      spur_en = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset_state", 128'(state_o), 128'(ST_IDLE));
      check("reset_mm_start", 128'(mm_start), 128'(1'b0));
      check("reset_done", 128'(done), 128'(1'b0));
      check("reset_busy", 128'(busy), 128'(1'b0));
      check("reset_r", 128'(r), 128'(0));
      check("reset_mm_a", 128'(mm_a), 128'(0));
      check("reset_mm_b", 128'(mm_b), 128'(0));
      RESET = 1'b0;
      repeat (10) @(negedge CLK);
      check("idle_spurious_state", 128'(state_o), 128'(ST_IDLE));
      check("idle_spurious_no_mm", 128'(mm_cnt), 128'(0));

      run_case("basic", 64'd4, 64'd13, 64'd497, 5, 1'b0, 0);
      run_case("e_zero", 64'd7, 64'd0, 64'd11, 5, 1'b0, 0);
      run_case("e_ones", 64'd2, '1, (64'd1 << 61) - 64'd1, 5, 1'b0, 0);
      run_case("restart_ignored", 64'd4, 64'd13, 64'd497, 5, 1'b0, 10);
      reset_mid_sqr();
      run_case("after_reset", 64'd4, 64'd13, 64'd497, 5, 1'b0, 0);

      for (int k = 0; k < 5; k++) begin
         mi = {$urandom, $urandom};
         ei = (k == 0) ? (64'd1 << $urandom_range(0, 63)) : {$urandom, $urandom};
         ni = {$urandom, $urandom};
         ni[63] = 1'b1;
         ni[0]  = 1'b1;
         run_case($sformatf("rand%0d", k), mi, ei, ni, 0, 1'b1, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
